// File: rtl/hazard_forward_ctrl.sv
// Hazard and forwarding control for the 5-stage MIPS32 pipeline.
// Covers EX operand forwarding, load-use stalls, mult/div stall sequencing and a stall counter.
module hazard_forward_ctrl #(
    parameter int MD_LATENCY = 4,
    parameter int CNT_W      = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [4:0]       Rs_EX,
    input  logic [4:0]       Rt_EX,
    input  logic [4:0]       Rd_MEM,
    input  logic             RegWrite_MEM,
    input  logic [4:0]       Rd_WB,
    input  logic             RegWrite_WB,
    input  logic             MemRead_EX,
    input  logic [4:0]       Rs_ID,
    input  logic [4:0]       Rt_ID,
    input  logic             MD_Start_ID,
    output logic [1:0]       Forward_A,
    output logic [1:0]       Forward_B,
    output logic             PC_Write,
    output logic             IF_ID_Write,
    output logic             ID_EX_Flush,
    output logic             MD_Busy,
    output logic             MD_Done,
    output logic [CNT_W-1:0] Stall_Cycles
);

    typedef enum logic {
        IDLE    = 1'b0,
        MD_BUSY = 1'b1
    } state_t;

    state_t     state;
    logic [3:0] count;
    logic       load_use;
    logic       stall;

    // MEM result is younger than WB, so it takes priority
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic [4:0] rd_mem,
        input logic       we_mem,
        input logic [4:0] rd_wb,
        input logic       we_wb
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (we_mem && rd_mem != 5'd0 && rd_mem == src)
            sel = 2'b10;
        else if (we_wb && rd_wb != 5'd0 && rd_wb == src)
            sel = 2'b01;
        return sel;
    endfunction

    assign Forward_A = fwd_sel(Rs_EX, Rd_MEM, RegWrite_MEM, Rd_WB, RegWrite_WB);
    assign Forward_B = fwd_sel(Rt_EX, Rd_MEM, RegWrite_MEM, Rd_WB, RegWrite_WB);

    assign load_use = MemRead_EX && (Rt_EX != 5'd0)
                   && (Rt_EX == Rs_ID || Rt_EX == Rt_ID);

    assign MD_Busy = (state == MD_BUSY);
    assign MD_Done = (state == MD_BUSY) && (count == 4'd0);

    // Load-use only matters in IDLE; a busy front end is already held
    assign stall       = MD_Busy || load_use;
    assign PC_Write    = !stall;
    assign IF_ID_Write = !stall;
    assign ID_EX_Flush = stall;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            count <= 4'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!load_use && MD_Start_ID) begin
                        state <= MD_BUSY;
                        count <= 4'(MD_LATENCY - 1);
                    end
                end
                MD_BUSY: begin
                    if (count == 4'd0)
                        state <= IDLE;
                    else
                        count <= count - 4'd1;
                end
                default: begin
                    state <= IDLE;
                    count <= 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            Stall_Cycles <= '0;
        else if (!PC_Write && Stall_Cycles != '1)
            Stall_Cycles <= Stall_Cycles + CNT_W'(1);
    end

endmodule

// File: doc/hazard_forward_ctrl.md
Name: hazard_forward_ctrl

Overview:
- Pipeline hazard controller for the 5-stage MIPS32 core.
- Produces the Forward_A/Forward_B selects consumed by the EX-stage operand forwarding muxes.
- Detects load-use hazards and sequences a multi-cycle multiply/divide stall. Drives PC/IF_ID write enables and the ID/EX bubble flush.
- Keeps a saturating stall-cycle counter for performance debug.

Parameters:
- MD_LATENCY, 4: cycles the front end is held per mult/div operation; legal range 1..15.
- CNT_W, 16: width of Stall_Cycles.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Rs_EX  input  5  rs field of the instruction in EX.
- Rt_EX  input  5  rt field of the instruction in EX.
- Rd_MEM  input  5  destination register in MEM.
- RegWrite_MEM  input  1  MEM instruction writes the register file.
- Rd_WB  input  5  destination register in WB.
- RegWrite_WB  input  1  WB instruction writes the register file.
- MemRead_EX  input  1  EX instruction is a load; its destination is Rt_EX.
- Rs_ID  input  5  rs field in ID.
- Rt_ID  input  5  rt field in ID.
- MD_Start_ID  input  1  ID instruction is mult/multu/div/divu.
- Forward_A  output  2  operand A select: 00 register file, 01 Write_Data_WB, 10 ALU_Result_MEM.
- Forward_B  output  2  operand B select, same encoding.
- PC_Write  output  1  PC update enable.
- IF_ID_Write  output  1  IF/ID register write enable.
- ID_EX_Flush  output  1  load a bubble (control zeros) into ID/EX.
- MD_Busy  output  1  mult/div stall in progress.
- MD_Done  output  1  one-cycle pulse in the final busy cycle.
- Stall_Cycles  output  CNT_W  count of cycles with PC_Write=0.

Behaviour:
- Forwarding is combinational and evaluated for A (Rs_EX) and B (Rt_EX) independently:
  - 10 if RegWrite_MEM, Rd_MEM!=0 and Rd_MEM==source.
  - Otherwise 01 if RegWrite_WB, Rd_WB!=0 and Rd_WB==source.
  - Otherwise 00.
  - MEM beats WB when both match. 11 is never driven. $zero is never forwarded.
- Load-use hazard, LU, is combinational: MemRead_EX and Rt_EX!=0 and (Rt_EX==Rs_ID or Rt_EX==Rt_ID).
- FSM states are IDLE and MD_BUSY, plus a 4-bit down-counter Count.
- In IDLE:
  - If LU: PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1 for this cycle only, and the state stays IDLE. The load advances, so LU clears on the next cycle and the total load-use stall is exactly 1 cycle.
  - Else if MD_Start_ID: no stall this cycle and the md instruction advances to EX. Next edge: state becomes MD_BUSY, Count becomes MD_LATENCY-1.
  - Else: PC_Write=1, IF_ID_Write=1, ID_EX_Flush=0.
- LU and MD_Start_ID in the same cycle: LU wins. The md instruction is held in ID and re-evaluated next cycle, so at most one md start occurs per instruction.
- In MD_BUSY:
  - PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1, MD_Busy=1, and LU is ignored.
  - Count decrements each cycle.
  - When Count==0, MD_Done=1 and the next state is IDLE.
  - The stall therefore lasts exactly MD_LATENCY cycles, and MD_Busy and MD_Done are Moore outputs of the state register.
- MD_Start_ID seen in the first IDLE cycle after busy starts a new sequence with no gap cycle.
- Stall_Cycles increments on every rising edge where PC_Write==0 and saturates at all-ones with no wrap.
- Reset, asynchronous, including mid-sequence:
  - State becomes IDLE, Count=0, Stall_Cycles=0.
  - Outputs immediately become PC_Write=1, IF_ID_Write=1, ID_EX_Flush=0, MD_Busy=0, MD_Done=0.
  - Forward_A/B follow their inputs, and are 00 if the inputs are 0.
  - A busy sequence interrupted by reset is abandoned, not resumed.
- All outputs are known (no X) from reset onward.

Test Plan:
- Rs_EX=5, Rd_MEM=5, RegWrite_MEM=1, Rd_WB=5, RegWrite_WB=1 -> Forward_A=10. Drop RegWrite_MEM -> Forward_A=01. Rd_MEM=Rd_WB=0 with RegWrite -> Forward_A=00.
- Rt_EX=7, Rd_WB=7, RegWrite_WB=1, Rs_EX=3, Rd_MEM=3, RegWrite_MEM=1 -> Forward_A=10, Forward_B=01, same cycle.
- MemRead_EX=1, Rt_EX=8, Rs_ID=8 for one cycle -> PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1 that cycle only; Stall_Cycles 0->1. Repeat with Rt_EX=0 -> no stall.
- MD_LATENCY=4, MD_Start_ID pulse in IDLE -> next 4 cycles MD_Busy=1 and PC_Write=0, MD_Done=1 on the 4th only, then PC_Write=1; Stall_Cycles=4.
- LU and MD_Start_ID asserted together -> 1-cycle load stall, MD_Busy stays 0. MD_Start_ID held with LU cleared next cycle -> busy begins one cycle later.
- Reset asserted asynchronously in the 2nd busy cycle -> MD_Busy=0, PC_Write=1, Stall_Cycles=0 before the next clock edge. After release, IDLE with no residual MD_Done.
